// File: rtl/bus_target.sv
// Memory-mapped CPU bus target: byte RAM plus LED/STATUS register bank, fixed 3-cycle handshake.
// Define BUS_TARGET_TIMER_EN to add a free-running 16-bit timer at IO_BASE+2/+3.
module bus_target #(
  parameter int unsigned RAM_DEPTH = 256,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic        read,
  input  logic [15:0] address,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        ready,
  output logic        busy,
  output logic [7:0]  led
);

  localparam int unsigned AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);
  localparam logic [15:0] ADDR_LED  = IO_BASE;
  localparam logic [15:0] ADDR_STAT = IO_BASE + 16'd1;
  localparam logic [15:0] ADDR_TLO  = IO_BASE + 16'd2;
  localparam logic [15:0] ADDR_THI  = IO_BASE + 16'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        wr_q;
  logic [7:0]  mem [RAM_DEPTH];
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  led_q, led_d;
  logic        err_q, err_d;
  logic        accept;
  logic        hit_ram, hit_led, hit_stat, hit_tlo, hit_thi, hit_any;
  logic [7:0]  rdata;

  assign hit_ram  = ({1'b0, addr_q} < RAM_LIMIT);
  assign hit_led  = (addr_q == ADDR_LED);
  assign hit_stat = (addr_q == ADDR_STAT);

`ifdef BUS_TARGET_TIMER_EN
  logic [15:0] timer_q;
  logic [7:0]  shadow_q;

  assign hit_tlo = (addr_q == ADDR_TLO);
  assign hit_thi = (addr_q == ADDR_THI);

  // Reading the low byte freezes the high byte so a LO/HI pair is coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= 16'h0000;
      shadow_q <= 8'h00;
    end else begin
      timer_q <= timer_q + 16'd1;
      if (state_q == ACCESS && !wr_q && hit_tlo) shadow_q <= timer_q[15:8];
    end
  end
`else
  assign hit_tlo = 1'b0;
  assign hit_thi = 1'b0;
`endif

  assign hit_any = hit_ram | hit_led | hit_stat | hit_tlo | hit_thi;

  always_comb begin
    rdata = 8'h00;
    if (hit_ram)       rdata = mem[addr_q[AW-1:0]];
    else if (hit_led)  rdata = led_q;
    else if (hit_stat) rdata = {7'b0, err_q};
`ifdef BUS_TARGET_TIMER_EN
    else if (hit_tlo)  rdata = timer_q[7:0];
    else if (hit_thi)  rdata = shadow_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    led_d   = led_q;
    err_d   = err_q;
    accept  = 1'b0;
    busy    = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          accept  = 1'b1;
          state_d = ACCESS;
          if (read && write) err_d = 1'b1;
        end
      end
      ACCESS: begin
        busy    = 1'b1;
        state_d = RESP;
        if (!wr_q) dout_d = rdata;
        if (!hit_any) begin
          err_d = 1'b1;
        end else if (wr_q) begin
          if (hit_led)                  led_d = wdata_q;
          else if (hit_stat && wdata_q[0]) err_d = 1'b0;
          else if (hit_tlo || hit_thi)  err_d = 1'b1;
        end
      end
      RESP: begin
        busy    = 1'b1;
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dout_q  <= 8'h00;
      led_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  // Request capture and RAM array carry no reset; a write issued in ACCESS commits even under rst.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= address;
      wdata_q <= din;
      wr_q    <= write;
    end
    if (state_q == ACCESS && wr_q && hit_ram) mem[addr_q[AW-1:0]] <= wdata_q;
  end

  assign dout = dout_q;
  assign led  = led_q;

endmodule

// File: tb/tb_bus_target.sv
// Directed self-checking bench for bus_target (default build; timer checks when BUS_TARGET_TIMER_EN is defined).
module tb_bus_target;

  logic        clk, rst, write, read;
  logic [15:0] address;
  logic [7:0]  din, dout, led;
  logic        ready, busy;
  int          errors = 0;
  int          checks = 0;

  bus_target #(.RAM_DEPTH(256), .IO_BASE(16'hFF00)) dut (
    .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
    .din(din), .dout(dout), .ready(ready), .busy(busy), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  // Drive one strobe cycle N and observe cycles N+1..N+4 at the falling edge.
  task automatic do_req(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d,
                        output int rcyc, output int rcnt, output logic [7:0] rdat,
                        output logic busy1, output logic [7:0] led2);
    @(negedge clk);
    write = wr; read = rd; address = a; din = d;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    busy1 = busy; rcyc = -1; rcnt = 0; rdat = 8'h00; led2 = 8'h00;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) led2 = led;
      if (ready === 1'b1) begin
        rcnt++;
        if (rcyc < 0) begin rcyc = k; rdat = dout; end
      end
    end
  endtask

  task automatic test_reset();
    int rc, rn; logic [7:0] rv, l2; logic b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
    rst = 1'b0;
    do_req(1'b0, 1'b1, 16'hFF01, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", rv); end
  endtask

  task automatic test_ram();
    int rc, rn; logic [7:0] rv, l2; logic b1;
    do_req(1'b1, 1'b0, 16'h0010, 8'hA5, rc, rn, rv, b1, l2);
    checks++; if (rc !== 2) begin errors++; $display("FAIL ram_wr_latency: got %0d expected 2", rc); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL ram_wr_busy: got %b expected 1", b1); end
    do_req(1'b0, 1'b1, 16'h0010, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rc !== 2) begin errors++; $display("FAIL ram_rd_latency: got %0d expected 2", rc); end
    checks++; if (rn !== 1) begin errors++; $display("FAIL ram_rd_readycount: got %0d expected 1", rn); end
    checks++; if (rv !== 8'hA5) begin errors++; $display("FAIL ram_rd_data: got %h expected a5", rv); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL ram_dout_hold: got %h expected a5", dout); end
    do_req(1'b1, 1'b0, 16'h00FF, 8'h5A, rc, rn, rv, b1, l2);
    do_req(1'b0, 1'b1, 16'h00FF, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h5A) begin errors++; $display("FAIL ram_top_addr: got %h expected 5a", rv); end
    do_req(1'b0, 1'b1, 16'hFF01, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL ram_err_clear: got %h expected 00", rv); end
  endtask

  task automatic test_led();
    int rc, rn; logic [7:0] rv, l2; logic b1;
    do_req(1'b1, 1'b0, 16'hFF00, 8'h3C, rc, rn, rv, b1, l2);
    checks++; if (l2 !== 8'h3C) begin errors++; $display("FAIL led_at_n2: got %h expected 3c", l2); end
    checks++; if (rc !== 2) begin errors++; $display("FAIL led_wr_latency: got %0d expected 2", rc); end
    do_req(1'b0, 1'b1, 16'hFF00, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h3C) begin errors++; $display("FAIL led_readback: got %h expected 3c", rv); end
  endtask

  task automatic test_unmapped();
    int rc, rn; logic [7:0] rv, l2; logic b1;
    do_req(1'b0, 1'b1, 16'h8000, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rc !== 2) begin errors++; $display("FAIL unmap_ready: got %0d expected 2", rc); end
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL unmap_data: got %h expected 00", rv); end
    do_req(1'b0, 1'b1, 16'hFF01, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h01) begin errors++; $display("FAIL unmap_err_set: got %h expected 01", rv); end
    do_req(1'b1, 1'b0, 16'hFF01, 8'h01, rc, rn, rv, b1, l2);
    do_req(1'b0, 1'b1, 16'hFF01, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL status_w1c: got %h expected 00", rv); end
    do_req(1'b1, 1'b0, 16'h0100, 8'h77, rc, rn, rv, b1, l2);
    do_req(1'b0, 1'b1, 16'hFF01, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h01) begin errors++; $display("FAIL ram_edge_unmapped: got %h expected 01", rv); end
    do_req(1'b1, 1'b0, 16'hFF01, 8'h01, rc, rn, rv, b1, l2);
    do_req(1'b1, 1'b1, 16'h0020, 8'h11, rc, rn, rv, b1, l2);
    checks++; if (rc !== 2) begin errors++; $display("FAIL both_ready: got %0d expected 2", rc); end
    do_req(1'b0, 1'b1, 16'hFF01, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h01) begin errors++; $display("FAIL both_err: got %h expected 01", rv); end
    do_req(1'b0, 1'b1, 16'h0020, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h11) begin errors++; $display("FAIL both_is_write: got %h expected 11", rv); end
    do_req(1'b1, 1'b0, 16'hFF01, 8'h01, rc, rn, rv, b1, l2);
  endtask

  task automatic test_back_to_back();
    int rc, rn; logic [7:0] rv, l2; logic b1;
    int cnt;
    @(negedge clk);
    read = 1'b1; address = 16'h0010; din = 8'h00;
    @(negedge clk);
    read = 1'b0; write = 1'b1; address = 16'h0010; din = 8'hFF;
    @(negedge clk);
    write = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_n2: got %b expected 1", ready); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL b2b_data: got %h expected a5", dout); end
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ready === 1'b1) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL b2b_extra_ready: got %0d expected 0", cnt); end
    do_req(1'b0, 1'b1, 16'h0010, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'hA5) begin errors++; $display("FAIL b2b_ram_unchanged: got %h expected a5", rv); end
  endtask

  task automatic test_rst_abort();
    int rc, rn; logic [7:0] rv, l2; logic b1;
    int cnt;
    do_req(1'b0, 1'b1, 16'hFF00, 8'h00, rc, rn, rv, b1, l2);
    @(negedge clk);
    read = 1'b1; address = 16'hFF00;
    @(negedge clk);
    read = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL abort_led: got %h expected 00", led); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL abort_dout: got %h expected 00", dout); end
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ready === 1'b1) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL abort_late_ready: got %0d expected 0", cnt); end
    @(negedge clk);
    write = 1'b1; address = 16'h0030; din = 8'h99;
    @(negedge clk);
    write = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 1'b1, 16'h0030, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h99) begin errors++; $display("FAIL abort_write_commit: got %h expected 99", rv); end
  endtask

  task automatic test_timer();
    int rc, rn; logic [7:0] rv, l2; logic b1;
`ifdef BUS_TARGET_TIMER_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    do_req(1'b0, 1'b1, 16'hFF02, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'hFC) begin errors++; $display("FAIL timer_lo_1: got %h expected fc", rv); end
    do_req(1'b0, 1'b1, 16'hFF03, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL timer_hi_shadow: got %h expected 00", rv); end
    do_req(1'b0, 1'b1, 16'hFF02, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h06) begin errors++; $display("FAIL timer_lo_2: got %h expected 06", rv); end
    do_req(1'b0, 1'b1, 16'hFF03, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h01) begin errors++; $display("FAIL timer_hi_2: got %h expected 01", rv); end
    do_req(1'b1, 1'b0, 16'hFF02, 8'h55, rc, rn, rv, b1, l2);
    do_req(1'b0, 1'b1, 16'hFF01, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h01) begin errors++; $display("FAIL timer_wr_err: got %h expected 01", rv); end
`else
    do_req(1'b0, 1'b1, 16'hFF02, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL notimer_lo_data: got %h expected 00", rv); end
    checks++; if (rc !== 2) begin errors++; $display("FAIL notimer_ready: got %0d expected 2", rc); end
    do_req(1'b0, 1'b1, 16'hFF01, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h01) begin errors++; $display("FAIL notimer_err: got %h expected 01", rv); end
    do_req(1'b1, 1'b0, 16'hFF01, 8'h01, rc, rn, rv, b1, l2);
    do_req(1'b1, 1'b0, 16'hFF03, 8'h12, rc, rn, rv, b1, l2);
    do_req(1'b0, 1'b1, 16'hFF01, 8'h00, rc, rn, rv, b1, l2);
    checks++; if (rv !== 8'h01) begin errors++; $display("FAIL notimer_hi_err: got %h expected 01", rv); end
`endif
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0; address = 16'h0000; din = 8'h00;
    test_reset();
    test_ram();
    test_led();
    test_unmapped();
    test_back_to_back();
    test_rst_abort();
    test_timer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_target.md
# bus_target

Memory-mapped responder for the CPU data bus: the target end of the `write`/`read`/`address[16]`/`dout[8]`/`din[8]` interface driven by the CPU core. It decodes each bus request into an on-chip byte RAM or a small I/O register bank. It returns read data with a fixed latency and a one-cycle `ready` acknowledge. It sits between the CPU and board-level I/O (LEDs, optional timer) in the top-level design.

## Interface
- `RAM_DEPTH`, 256: bytes of RAM mapped at 16h0000; power of two, 2–4096.
- `IO_BASE`, 16hFF00: base address of the I/O register bank; must be ≥ `RAM_DEPTH`.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `write` input 1: CPU write strobe, one-cycle pulse.
- `read` input 1: CPU read strobe, one-cycle pulse.
- `address` input 16: byte address, sampled with the strobe.
- `din` input 8: write data from the CPU (CPU `dout`), sampled with `write`.
- `dout` output 8: read data to the CPU (CPU `din`); valid while `ready`=1, held afterwards.
- `ready` output 1: one-cycle completion pulse for every accepted request.
- `busy` output 1: high while a request is in flight; strobes are ignored while high.
- `led` output 8: LED register contents.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on `read` or `write`, latch address/data/kind, go to ACCESS, `busy`=1.
  - If both strobes are high in the same cycle, the request is a write and the error bit is set.
- ACCESS: perform the RAM write, or issue the RAM/register read. Go to RESP.
- RESP: drive `ready`=1. For reads, load `dout` from the RAM output or the register mux. Return to IDLE, `busy`=0.
- Address map:
  - `address` < `RAM_DEPTH`: RAM, read/write.
  - `IO_BASE`+0: LED register, read/write.
  - `IO_BASE`+1: STATUS. bit0 = sticky ERR; other bits read 0. Writing 1 to bit0 clears ERR.
  - `IO_BASE`+2: TIMER_LO. `IO_BASE`+3: TIMER_HI (timer build only; see Configuration).
  - Anything else is unmapped: reads return 8h00, writes are dropped, ERR is set. The request still completes with `ready`.
- RAM contents are undefined after power-up and are not cleared by `rst`.

## Timing
- Request accepted in cycle N (strobe high, `busy`=0).
- `busy`=1 in cycles N+1 and N+2.
- `ready`=1 in cycle N+2 only; read data is valid on `dout` in N+2.
- Latency is the same for reads and writes, and for RAM and I/O targets.
- Earliest next accept is cycle N+3, giving a peak rate of one request per 3 cycles.
- Strobes arriving while `busy`=1 are dropped silently: no `ready`, no side effect.
- A write followed by a read of the same address returns the new value.
- Reset values: `ready`=0, `busy`=0, `dout`=8h00, `led`=8h00, ERR=0, FSM=IDLE, timer=0.
- `rst` mid-request aborts it: no `ready` is issued. A RAM write already committed in ACCESS persists.

## Configuration
- `BUS_TARGET_TIMER_EN` defined: a 16-bit free-running counter is compiled in.
  - It increments every cycle and wraps 16hFFFF→16h0000.
  - Reading TIMER_LO returns the low byte and latches the high byte into a shadow register; TIMER_HI returns the shadow.
  - Timer registers are read-only; writes to them set ERR.
- `BUS_TARGET_TIMER_EN` undefined: no counter or shadow logic. `IO_BASE`+2/+3 decode as unmapped.

## Test plan
- Write 8hA5 to 16h0010; read 16h0010 → `ready` at N+2 both times, read `dout`=8hA5, ERR=0.
- Write 8h3C to `IO_BASE` → `led`=8h3C from cycle N+2; read back gives 8h3C.
- Read 16h8000 (unmapped) → `dout`=8h00 with `ready`, STATUS reads 8h01; write 8h01 to STATUS → STATUS reads 8h00.
- Issue a read at N, then `write` at N+1 → only one `ready` (at N+2), RAM unchanged by the second strobe.
- Assert `rst` in cycle N+1 of a read → no `ready`; `led`, `dout`, `busy` return to 0.
- Timer build: after reset, read TIMER_LO, then TIMER_HI once the counter crosses 16h00FF/16h0100 → HI matches the value latched with LO. Non-timer build: same addresses set ERR.
